// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host frame receiver with clock filter and watchdog
//
// Deserializes 11-bit PS/2 frames (start, 8 data LSB first, odd parity, stop).
// The raw pins are synchronized, and PS2_CLK is deglitched. Accepted bytes are
// presented on hex_data with a one-cycle data_ready strobe. Rejected frames
// produce a one-cycle err strobe.
//
// Ports:
//   CLK        system clock, rising edge
//   RST_N      asynchronous active-low reset
//   PS2_CLK    raw keyboard clock pin (asynchronous)
//   PS2_DATA   raw keyboard data pin (asynchronous)
//   data_ready one-cycle strobe, hex_data holds a new valid byte
//   hex_data   last valid received byte
//   err        one-cycle strobe, frame rejected (parity or stop error)
module ps2_rx #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 100000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic       data_ready,
  output logic [7:0] hex_data,
  output logic       err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [FCW-1:0] FLT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t         state, state_d;
  logic           clk_s1, clk_s2, dat_s1, dat_s2;
  logic           filt_clk;
  logic [FCW-1:0] flt_cnt;
  logic           fall;
  logic [WDW-1:0] wd_cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           par_bit;

  logic           shift_en, clr_bits, par_en, check, frame_ok;

  // Two-flop synchronizers; pins idle high.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= PS2_CLK;
      clk_s2 <= clk_s1;
      dat_s1 <= PS2_DATA;
      dat_s2 <= dat_s1;
    end
  end

  // Clock deglitcher: flip the filtered level on the FILTER_LEN-th
  // consecutive disagreeing sample. fall is registered alongside the flip.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      filt_clk <= 1'b1;
      flt_cnt  <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s2 != filt_clk) begin
        if (flt_cnt == FLT_LAST) begin
          filt_clk <= clk_s2;
          flt_cnt  <= '0;
          fall     <= filt_clk;
        end else begin
          flt_cnt <= flt_cnt + 1'b1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_d;
  end

  // A fall edge takes priority over the watchdog expiring in the same cycle.
  always_comb begin
    state_d  = state;
    shift_en = 1'b0;
    clr_bits = 1'b0;
    par_en   = 1'b0;
    check    = 1'b0;
    if (fall) begin
      case (state)
        IDLE: begin
          if (!dat_s2) begin
            state_d  = DATA;
            clr_bits = 1'b1;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_en  = 1'b1;
          state_d = STOP;
        end
        STOP: begin
          check   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state != IDLE && wd_cnt == WD_LIMIT) begin
      state_d  = IDLE;
      clr_bits = 1'b1;
    end
  end

  // Stop bit high and odd parity over data plus parity bit.
  assign frame_ok = dat_s2 & (^shreg ^ par_bit);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wd_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      hex_data   <= 8'h00;
      data_ready <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (fall || state == IDLE)  wd_cnt <= '0;
      else if (wd_cnt != WD_LIMIT) wd_cnt <= wd_cnt + 1'b1;

      if (clr_bits) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 1'b1;
        shreg   <= {dat_s2, shreg[7:1]};
      end

      if (par_en) par_bit <= dat_s2;

      data_ready <= check & frame_ok;
      err        <= check & ~frame_ok;
      if (check && frame_ok) hex_data <= shreg;
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - scoreboard testbench for ps2_rx
module tb_ps2_rx;

  localparam int FL  = 4;
  localparam int TO  = 500;
  localparam int HP  = 20;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DATA = 1'b1;
  logic       data_ready;
  logic [7:0] hex_data;
  logic       err;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] prev_hex = 8'h00;

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .data_ready(data_ready), .hex_data(hex_data), .err(err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #5ms;
    $display("FAIL time_limit: simulation did not finish, required finish before 5ms");
    $fatal(1, "time limit");
  end

  // Monitor: pops the scoreboard on every strobe.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (data_ready && err) begin
        checks++; errors++;
        $display("FAIL strobe_overlap: data_ready=1 err=1, required not both high");
      end
      if (data_ready || err) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: data_ready=%0b err=%0b hex=%02h, required none", data_ready, err, hex_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.is_err != err || (!e.is_err && hex_data != e.data)) begin
            errors++;
            $display("FAIL frame_result: err=%0b hex=%02h, required err=%0b hex=%02h", err, hex_data, e.is_err, e.data);
          end
        end
      end
      if (hex_data != prev_hex && !data_ready) begin
        checks++; errors++;
        $display("FAIL hex_stable: hex changed %02h->%02h without data_ready", prev_hex, hex_data);
      end
    end
    prev_hex = hex_data;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // One PS/2 bit: data set during clock high, device-side sampled on fall.
  task automatic send_bit(input bit b, input bit glitch);
    PS2_DATA = b;
    if (glitch) begin
      wait_cyc(8);
      PS2_CLK = 1'b0;
      wait_cyc(2);
      PS2_CLK = 1'b1;
      wait_cyc(HP - 10);
    end else begin
      wait_cyc(HP);
    end
    PS2_CLK = 1'b0;
    wait_cyc(HP);
    PS2_CLK = 1'b1;
  endtask

  // Sends the first nbits of a frame (11 for a complete one).
  task automatic send_frame(input logic [7:0] d, input bit par, input int nbits, input bit glitch);
    logic [10:0] f;
    f = {1'b1, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i], glitch);
    PS2_DATA = 1'b1;
  endtask

  task automatic expect_ok(input logic [7:0] d);
    exp_t e;
    e.is_err = 1'b0; e.data = d;
    sb.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1; e.data = 8'h00;
    sb.push_back(e);
  endtask

  task automatic check_hex(input string name, input logic [7:0] req);
    checks++;
    if (hex_data !== req) begin
      errors++;
      $display("FAIL %s: hex_data=%02h, required %02h", name, hex_data, req);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected strobes missing, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (data_ready !== 1'b0 || err !== 1'b0 || hex_data !== 8'h00) begin
      errors++;
      $display("FAIL %s: dr=%0b err=%0b hex=%02h, required 0 0 00", name, data_ready, err, hex_data);
    end
  endtask

  initial begin
    wait_cyc(3);
    check_reset_outputs("reset_state");
    RST_N = 1'b1;
    wait_cyc(10);
    check_reset_outputs("post_reset_idle");

    expect_ok(8'h12);
    send_frame(8'h12, 1'b1, 11, 1'b0);
    wait_cyc(40);
    check_drained("frame_12");
    check_hex("hex_12", 8'h12);

    expect_ok(8'h01);
    expect_ok(8'h1E);
    send_frame(8'h01, 1'b0, 11, 1'b0);
    send_frame(8'h1E, 1'b1, 11, 1'b0);
    wait_cyc(40);
    check_drained("back_to_back");
    check_hex("hex_1e", 8'h1E);

    expect_err();
    send_frame(8'h0C, 1'b0, 11, 1'b0);
    wait_cyc(40);
    check_drained("bad_parity");
    check_hex("hex_after_err", 8'h1E);

    expect_ok(8'h02);
    send_frame(8'h02, 1'b0, 11, 1'b0);
    wait_cyc(40);
    check_drained("frame_02");
    check_hex("hex_02", 8'h02);

    // Bad stop bit.
    expect_err();
    begin
      logic [10:0] f;
      f = {1'b0, 1'b1, 8'h12, 1'b0};
      for (int i = 0; i < 11; i++) send_bit(f[i], 1'b0);
      PS2_DATA = 1'b1;
    end
    wait_cyc(40);
    check_drained("bad_stop");
    check_hex("hex_after_stop_err", 8'h02);

    // Truncated frame: start + 5 data bits, watchdog must recover.
    send_frame(8'h0C, 1'b1, 6, 1'b0);
    wait_cyc(TO + 100);
    check_drained("timeout_no_strobe");
    expect_ok(8'h0C);
    send_frame(8'h0C, 1'b1, 11, 1'b0);
    wait_cyc(40);
    check_drained("frame_0c_after_timeout");
    check_hex("hex_0c", 8'h0C);

    expect_ok(8'h12);
    send_frame(8'h12, 1'b1, 11, 1'b1);
    wait_cyc(40);
    check_drained("glitch_frame");
    check_hex("hex_12_glitch", 8'h12);

    // Reset mid-frame after the 4th data bit.
    send_frame(8'h1E, 1'b1, 5, 1'b0);
    RST_N = 1'b0;
    wait_cyc(1);
    check_reset_outputs("mid_frame_reset_0");
    wait_cyc(2);
    check_reset_outputs("mid_frame_reset_2");
    RST_N = 1'b1;
    wait_cyc(10);
    expect_ok(8'h1E);
    send_frame(8'h1E, 1'b1, 11, 1'b0);
    wait_cyc(40);
    check_drained("frame_1e_after_reset");
    check_hex("hex_1e_after_reset", 8'h1E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
# ps2_rx

PS/2 keyboard receiver that deserializes 11-bit device-to-host frames from the raw PS2_CLK/PS2_DATA pins and presents each byte as `hex_data` with a one-cycle `data_ready` strobe. It sits directly upstream of the calculator core and feeds its `data_ready`/`hex_data` inputs. It also synchronizes and deglitches the pins, checks parity and stop bits, and recovers from truncated frames with a watchdog.

## Interface
- FILTER_LEN, 4: number of consecutive equal synchronized PS2_CLK samples required to change the filtered clock level (2..16).
- TIMEOUT, 100000: CLK cycles without a filtered PS2_CLK falling edge before an in-progress frame is abandoned (2 ms at 50 MHz).
- CLK  input  1  system clock; all state updates on its rising edge.
- RST_N  input  1  reset. One clock; reset is asynchronous and active-low.
- PS2_CLK  input  1  raw keyboard clock pin, asynchronous to CLK.
- PS2_DATA  input  1  raw keyboard data pin, asynchronous to CLK.
- data_ready  output  1  one-CLK-cycle strobe: a valid byte is now on `hex_data`.
- hex_data  output  8  last valid received byte; held until the next valid frame.
- err  output  1  one-CLK-cycle strobe: a frame was rejected (parity or stop error).

## Operation
- Both pins pass through a 2-flop synchronizer.
- PS2_CLK filter:
  - A counter tracks how long the synchronized level has differed from the filtered level.
  - The filtered level flips once FILTER_LEN consecutive differing samples are seen.
  - Any agreeing sample clears the counter.
  - Filtered level resets to 1.
- `fall` is a one-cycle internal strobe when the filtered clock goes 1→0. PS2_DATA (synchronized) is sampled only on `fall`.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0 (start bit), go to DATA and clear the bit counter. On `fall` with data=1, stay in IDLE and drop the bit.
  - DATA: on `fall`, shift data into the shift register LSB first (new bit enters at bit 7, shift right). After the 8th bit (counter 7→wrap), go to PARITY.
  - PARITY: on `fall`, store the bit and go to STOP.
  - STOP: on `fall`, the frame is valid if stop=1 and XOR of the 8 data bits and the parity bit = 1 (odd parity). Return to IDLE.
    - Valid frame: load `hex_data` from the shift register and pulse `data_ready`.
    - Invalid frame: pulse `err`; `hex_data` is unchanged.
- Watchdog:
  - Counter clears on every `fall` and while in IDLE.
  - In any non-IDLE state, reaching TIMEOUT forces IDLE and clears the bit counter.
  - A timeout raises no `err` and no `data_ready`.
- Counter width is $clog2(TIMEOUT+1). Bit counter is 3 bits.
- No host-to-device transmission; the pins are input-only.

## Timing
- Reset values: data_ready=0, err=0, hex_data=8'h00. FSM=IDLE, filtered clock=1, all counters 0, synchronizers=1.
- Latency from a PS2_CLK pin falling edge to `fall`: 2 (sync) + FILTER_LEN CLK cycles, ±1 for metastability resolution.
- `data_ready`/`err` assert the cycle after the `fall` that samples the stop bit.
  - Each is high for exactly 1 cycle.
  - They are never high together.
- `hex_data` changes in the same cycle `data_ready` rises and is stable at all other times.
- Back-to-back frames need no idle gap. A start bit `fall` in the cycle after STOP is accepted.
- Watchdog and `fall` in the same cycle: `fall` wins (edge processed, counter cleared).
- RST_N asserted mid-frame: immediate return to the reset values; the partial frame is discarded.
- Pulses on PS2_CLK shorter than FILTER_LEN CLK cycles produce no `fall`.

## Test plan
- Reset, then send frame 0x12 (data bits 0,1,0,0,1,0,0,0; parity 1; stop 1) at 12.5 kHz PS/2 clock → one `data_ready` pulse, hex_data=0x12, err never high.
- Send 0x01 (parity 0), then 0x1E (parity 1) back-to-back with no gap → two `data_ready` pulses; hex_data reads 0x01 then 0x1E.
- Send 0x0C with parity 0 (wrong) → one `err` pulse, no `data_ready`, hex_data stays at its previous value. Next, 0x02 (parity 0) sent correctly → hex_data=0x02.
- Send start + 5 data bits, then stop toggling PS2_CLK → FSM returns to IDLE exactly TIMEOUT cycles after the last `fall`, no strobes. A following full 0x0C frame (parity 1) → hex_data=0x0C.
- Inject 2-cycle low glitches on PS2_CLK mid-frame of 0x12 (FILTER_LEN=4) → no extra bits shifted; hex_data=0x12 with no err.
- Deassert RST_N for 3 cycles after the 4th data bit, then send full 0x1E → outputs read reset values during reset; afterwards a single `data_ready` with hex_data=0x1E.
